// File: rtl/prbs31_checker_if.sv
// Bit-stream bundle between a PRBS31 source and the PRBS31 checker.
// The master drives the received bits; the slave reports lock and error status.
interface prbs31_checker_if #(
   parameter int CNT_W = 16
) ();
   logic             din;
   logic             din_valid;
   logic             clear_cnt;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;

   modport master (
      output din, din_valid, clear_cnt,
      input  locked, err_pulse, err_count
   );

   modport slave (
      input  din, din_valid, clear_cnt,
      output locked, err_pulse, err_count
   );
endinterface

// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) receive checker: self-synchronises in SEARCH, then counts
// bit errors against a free-running local reference in LOCKED and drops lock on error bursts.
module prbs31_checker #(
   parameter int LOCK_CNT   = 64,
   parameter int WIN        = 128,
   parameter int UNLOCK_ERR = 16,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   prbs31_checker_if.slave   bus
);
   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int WIN_W   = $clog2(WIN + 1);
   localparam int ERR_W   = $clog2(UNLOCK_ERR + 1);

   typedef enum logic {
      S_SEARCH = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t             r_state;
   logic [30:0]        r_hist;
   logic [4:0]         r_fill;
   logic [MATCH_W-1:0] r_match;
   logic [WIN_W-1:0]   r_win_bits;
   logic [ERR_W-1:0]   r_win_err;
   logic               r_locked;
   logic               r_err_pulse;
   logic [CNT_W-1:0]   r_err_count;

   logic               w_pred;
   logic               w_mismatch;
   logic               w_hist_zero;
   logic               w_filled;
   logic [MATCH_W-1:0] w_match_inc;
   logic [WIN_W-1:0]   w_win_bits_nxt;
   logic [ERR_W-1:0]   w_win_err_nxt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // h[0] is the newest bit, so h[27] and h[30] are b(n-28) and b(n-31)
   assign w_pred         = r_hist[27] ^ r_hist[30];
   assign w_mismatch     = bus.din ^ w_pred;
   assign w_hist_zero    = (r_hist == 31'd0);
   assign w_filled       = (r_fill == 5'd31);
   assign w_match_inc    = r_match + MATCH_W'(1);
   assign w_win_bits_nxt = r_win_bits + WIN_W'(1);
   assign w_win_err_nxt  = r_win_err + ERR_W'(w_mismatch);

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state     <= S_SEARCH;
         r_hist      <= 31'd0;
         r_fill      <= 5'd0;
         r_match     <= '0;
         r_win_bits  <= '0;
         r_win_err   <= '0;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_err_pulse <= 1'b0;
         if (bus.clear_cnt) begin
            r_err_count <= '0;
         end
         if (bus.din_valid) begin
            case (r_state)
               S_SEARCH: begin
                  r_hist <= {r_hist[29:0], bus.din};
                  if (!w_filled) begin
                     r_fill <= r_fill + 5'd1;
                  end else if (w_hist_zero || w_mismatch) begin
                     r_match <= '0;
                  end else if (w_match_inc == MATCH_W'(LOCK_CNT)) begin
                     r_state    <= S_LOCKED;
                     r_locked   <= 1'b1;
                     r_match    <= '0;
                     r_win_bits <= '0;
                     r_win_err  <= '0;
                  end else begin
                     r_match <= w_match_inc;
                  end
               end
               S_LOCKED: begin
                  // Feeding back the prediction keeps one flipped bit from causing a burst
                  r_hist      <= {r_hist[29:0], w_pred};
                  r_err_pulse <= w_mismatch;
                  if (w_mismatch) begin
                     r_err_count <= sat_inc(bus.clear_cnt ? {CNT_W{1'b0}} : r_err_count);
                  end
                  if (w_win_err_nxt == ERR_W'(UNLOCK_ERR)) begin
                     r_state    <= S_SEARCH;
                     r_locked   <= 1'b0;
                     r_fill     <= 5'd0;
                     r_match    <= '0;
                     r_win_bits <= '0;
                     r_win_err  <= '0;
                  end else if (w_win_bits_nxt == WIN_W'(WIN)) begin
                     r_win_bits <= '0;
                     r_win_err  <= '0;
                  end else begin
                     r_win_bits <= w_win_bits_nxt;
                     r_win_err  <= w_win_err_nxt;
                  end
               end
               default: begin
                  r_state <= S_SEARCH;
               end
            endcase
         end
      end
   end

   assign bus.locked    = r_locked;
   assign bus.err_pulse = r_err_pulse;
   assign bus.err_count = r_err_count;

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Receive-side companion to the team's PRBS31 generator (polynomial x^31 + x^28 + 1, recurrence b(n) = b(n-28) ^ b(n-31)).
- Takes a serial bit stream and self-synchronises to it with a SEARCH/LOCKED state machine.
- Once locked, counts bit errors against a free-running local reference and drops lock on excessive errors.
- Sits on the loopback path of the BIST/PRBS test block; results go to the status pins.

Parameters:
- LOCK_CNT, 64: consecutive correct predictions required to enter LOCKED.
- WIN, 128: length in valid bits of the error-monitoring window in LOCKED.
- UNLOCK_ERR, 16: errors within one window that force return to SEARCH.
- CNT_W, 16: width of the saturating error counter.

Ports:
- clk, input, 1: clock; all logic on the rising edge.
- rst_n, input, 1: reset; synchronous, active-high despite the name (fixed by codebase naming).
- din, input, 1: received serial bit.
- din_valid, input, 1: din is sampled only on cycles with this high; all state holds otherwise.
- clear_cnt, input, 1: synchronous clear of err_count.
- locked, output, 1: registered; high in LOCKED state.
- err_pulse, output, 1: registered; one-cycle pulse per detected error while LOCKED.
- err_count, output, CNT_W: registered; saturating error total.

Behaviour:
- Reset (rst_n=1 at an edge): state=SEARCH, 31-bit history=0, fill/match/window counters=0; locked=0, err_pulse=0, err_count=0. Reset overrides every other input, including mid-lock.
- History h[30:0]: h[0] is the most recent bit. Shift left on each valid bit. Prediction p = h[27] ^ h[30].
- SEARCH:
  - Shift the received din into h.
  - fill counts valid bits, saturating at 31. Before fill reaches 31, no comparison is made.
  - After fill reaches 31, each valid bit compares din with p.
  - A match increments match_cnt. A mismatch clears match_cnt to 0.
  - If h is all-zero, force match_cnt to 0, so all-zero input never locks.
  - When the LOCK_CNT-th consecutive match is sampled: state=LOCKED, locked=1 on that edge, window counters cleared.
  - From a clean stream, locked rises at the edge sampling valid bit index 94 (0-based), i.e. fill 31 + LOCK_CNT 64.
- LOCKED:
  - Shift p (not din) into h, so the reference free-runs and one flipped bit yields exactly one error.
  - If din != p: err_pulse=1 on the next cycle, err_count+1 (saturates at 2^CNT_W-1), win_err+1.
  - win_bits counts valid bits. When it reaches WIN, clear win_bits and win_err.
  - If win_err reaches UNLOCK_ERR: state=SEARCH, locked=0 on that edge, fill/match cleared. Relock then needs 95 good bits.
- err_pulse is 0 in SEARCH and on all non-valid cycles. Errors are never counted in SEARCH.
- clear_cnt has priority over an increment; if an error coincides with clear_cnt, err_count becomes 1.
- clear_cnt does not affect state, locked, or window counters.
- din_valid low: no shift, no counter changes, err_pulse=0.

Test Plan:
- Clean lock: drive the generator stream (seed 31'd1, output taken from bit 30), din_valid=1 continuously.
  - locked rises after exactly 95 valid bits.
  - err_count stays 0 over 10000 bits.
- Single flip: invert bit 500 of a locked stream.
  - Exactly one err_pulse, one cycle after that bit is sampled.
  - err_count=1, locked stays 1.
- Zero and garbage immunity:
  - 2000 bits of constant 0 never assert locked.
  - Constant 1 or alternating 1010 inputs never lock.
- Unlock and relock: in LOCKED, invert 16 bits within one 128-bit window.
  - locked falls at the 16th error, err_count=16.
  - Resume the clean stream: locked returns after 95 valid bits.
  - Invert only 15 bits per window: stays locked.
- Valid gaps: insert random din_valid=0 cycles into the clean stream.
  - Lock point is still valid-bit 95, with no errors.
  - err_pulse never asserts on invalid cycles.
- Counter edges, with CNT_W=4:
  - 20 errors leave err_count at 15.
  - clear_cnt together with an error gives err_count=1.
  - rst_n=1 mid-lock gives locked=0, err_count=0 on the next cycle.
